// File: rtl/mem8_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the 8-byte register memory.
// Define MEM8_ARB_FIXED_PRIO_EN for fixed priority (A always beats B).
module mem8_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_bar,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [2:0]        a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [2:0]        b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              busy,
  output logic [7:0]        mem_en,
  output logic              mem_rd_bar,
  output logic              mem_wr_bar,
  output logic [DATA_W-1:0] mem_w_data,
  input  logic [DATA_W-1:0] mem_r_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              owner_q, owner_d;   // 1 = port B
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              pick_b;

`ifdef MEM8_ARB_FIXED_PRIO_EN
  assign pick_b = ~a_req;
`else
  logic last_q, last_d;                  // 1 = B was served most recently

  assign pick_b = b_req & (~a_req | ~last_q);
`endif

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    owner_d   = owner_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
`ifndef MEM8_ARB_FIXED_PRIO_EN
    last_d    = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (a_req | b_req) begin
          state_d = ACCESS;
          owner_d = pick_b;
          we_d    = pick_b ? b_we    : a_we;
          addr_d  = pick_b ? b_addr  : a_addr;
          wdata_d = pick_b ? b_wdata : a_wdata;
`ifndef MEM8_ARB_FIXED_PRIO_EN
          last_d  = pick_b;
`endif
        end
      end
      ACCESS: state_d = CAPTURE;
      CAPTURE: begin
        state_d = DONE;
        if (!we_q) begin
          if (owner_q) b_rdata_d = mem_r_data;
          else         a_rdata_d = mem_r_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= 3'd0;
      wdata_q   <= '0;
      owner_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
`ifndef MEM8_ARB_FIXED_PRIO_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      owner_q   <= owner_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
`ifndef MEM8_ARB_FIXED_PRIO_EN
      last_q    <= last_d;
`endif
    end
  end

  // Strobes decode only from state and latched request, never from live inputs.
  logic strobe_rd, strobe_wr;

  assign strobe_rd  = ~we_q & ((state_q == ACCESS) | (state_q == CAPTURE));
  assign strobe_wr  = we_q & (state_q == ACCESS);
  assign mem_en     = (strobe_rd | strobe_wr) ? (8'b1 << addr_q) : 8'h00;
  assign mem_rd_bar = ~strobe_rd;
  assign mem_wr_bar = ~strobe_wr;
  assign mem_w_data = wdata_q;
  assign busy       = (state_q != IDLE);
  assign a_ack      = (state_q == DONE) & ~owner_q;
  assign b_ack      = (state_q == DONE) & owner_q;
  assign a_rdata    = a_rdata_q;
  assign b_rdata    = b_rdata_q;

endmodule
